// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for a fetch-decode-ALU-writeback pipeline: RAW scoreboard, dcache freeze, jump squash.
// Combinational stall/issue outputs; busy bits and dcache_req are registered; stalls hold decode until hazards clear.
module pipeline_ctrl #(
    parameter int REGSZ       = 5,
    parameter int NREGS       = 32,
    parameter int CNTW        = 2,
    parameter int MEM_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [REGSZ-1:0] dec_rs1,
    input  logic [REGSZ-1:0] dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [REGSZ-1:0] dec_rd,
    input  logic             dec_wr,
    input  logic             dec_mem,
    input  logic             alu_jmp,
    input  logic             dcache_done,
    input  logic             wb_valid,
    input  logic [REGSZ-1:0] wb_rd,
    output logic             stall_fetch,
    output logic             stall_dec,
    output logic             issue,
    output logic             bubble_alu,
    output logic             flush_dec,
    output logic             pc_redirect,
    output logic             dcache_req,
    output logic             mem_err,
    output logic [NREGS-1:0] busy_mask
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              dec_valid;
    logic [TW-1:0]     tmo_cnt;
    logic [CNTW-1:0]   cnt [NREGS];
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;
    logic              raw_hz;
    logic              sat_hz;
    logic              hazard;
    logic              bubble_int;

    // Hazards look at the registered counts only, so a same-cycle writeback does not bypass.
    always_comb begin
        raw_hz = dec_valid &
                 ((dec_rs1_used & (dec_rs1 != '0) & (cnt[dec_rs1] != '0)) |
                  (dec_rs2_used & (dec_rs2 != '0) & (cnt[dec_rs2] != '0)));
        sat_hz = dec_valid & dec_wr & (dec_rd != '0) & (cnt[dec_rd] == CNT_MAX);
        hazard = raw_hz | sat_hz;
    end

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        bubble_int  = 1'b0;
        stall_dec   = 1'b0;
        flush_dec   = 1'b0;
        pc_redirect = 1'b0;
        mem_err     = 1'b0;
        case (state)
            RUN: begin
                issue       = dec_valid & ~hazard & ~alu_jmp;
                bubble_int  = ~issue;
                flush_dec   = alu_jmp;
                pc_redirect = alu_jmp;
                stall_dec   = dec_valid & ~issue & ~alu_jmp;
                if (alu_jmp) begin
                    state_nxt = FLUSH;
                end else if (issue && dec_mem) begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stall_dec = 1'b1;
                if (dcache_done) begin
                    state_nxt = RUN;
                end else if (tmo_cnt == TMO_LAST) begin
                    mem_err   = 1'b1;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                // The squashed fetch never reaches decode, so the ALU gets a NOP.
                flush_dec  = 1'b1;
                bubble_int = 1'b1;
                state_nxt  = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        stall_fetch = stall_dec;
        bubble_alu  = rst & bubble_int;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            dec_valid  <= 1'b0;
            dcache_req <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            dcache_req <= issue & dec_mem;
            if (flush_dec) begin
                dec_valid <= 1'b0;
            end else if (!stall_dec) begin
                dec_valid <= fetch_valid;
            end
            if (state == MEM_WAIT && state_nxt == MEM_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // A writeback to an idle register is dropped so counters never wrap below zero.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 1; i < NREGS; i++) begin
            inc_v[i] = issue & dec_wr & (dec_rd == REGSZ'(i));
            dec_v[i] = wb_valid & (wb_rd == REGSZ'(i)) & (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (inc_v[i] && !dec_v[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_v[i] && !inc_v[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_mask[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the in-order fetch → decode → ALU → writeback pipeline.
- Tracks pending register writes with a per-register scoreboard and stalls decode on RAW hazards.
- Freezes the pipeline while a data-cache access is outstanding.
- Squashes wrong-path instructions when the ALU resolves a taken jump.

Parameters:
- REGSZ, 5, register index width.
- NREGS, 32, architectural register count (x0 never tracked).
- CNTW, 2, width of each scoreboard pending-write counter.
- MEM_TIMEOUT, 1023, max cycles in MEM_WAIT before mem_err pulses.

Ports:
- clk  in  1  clock
- rst  in  1  reset; active-low, asynchronous
- fetch_valid  in  1  icache returned an instruction this cycle (got_inst)
- dec_rs1  in  REGSZ  decoded source 1
- dec_rs2  in  REGSZ  decoded source 2
- dec_rs1_used  in  1  instruction reads rs1
- dec_rs2_used  in  1  instruction reads rs2
- dec_rd  in  REGSZ  decoded destination
- dec_wr  in  1  instruction writes rd
- dec_mem  in  1  instruction is a load/store
- alu_jmp  in  1  ALU resolved a taken jump/branch this cycle
- dcache_done  in  1  dcache operation_complete
- wb_valid  in  1  writeback commits this cycle
- wb_rd  in  REGSZ  writeback destination
- stall_fetch  out  1  hold PC and fetch stage
- stall_dec  out  1  hold decode register
- issue  out  1  decode → ALU transfer occurs this cycle
- bubble_alu  out  1  ALU stage loads a NOP
- flush_dec  out  1  invalidate decode register
- pc_redirect  out  1  select jump target for next_pc
- dcache_req  out  1  start data-cache access
- mem_err  out  1  one-cycle timeout pulse
- busy_mask  out  NREGS  bit i = register i has a pending write

Behaviour:
- Reset (rst low, async): all scoreboard counters 0, FSM = RUN, timeout counter 0, dec_valid 0. All outputs 0, busy_mask 0.
- dec_valid (internal):
  - set by fetch_valid when not stalled;
  - cleared by flush_dec;
  - held while stall_dec.
- RAW hazard: dec_valid & ((dec_rs1_used & rs1≠0 & cnt[rs1]≠0) | (dec_rs2_used & rs2≠0 & cnt[rs2]≠0)).
- Saturation hazard: dec_valid & dec_wr & rd≠0 & cnt[rd]==2^CNTW-1.
- issue = dec_valid & !hazard & state==RUN & !alu_jmp.
- bubble_alu = !issue whenever state==RUN.
- stall_dec = stall_fetch = dec_valid & !issue & !flush_dec.
- Scoreboard per register (combinational busy_mask = cnt≠0):
  - inc when issue & dec_wr & rd==i;
  - dec when wb_valid & wb_rd==i;
  - both in the same cycle → unchanged;
  - index 0 ignored;
  - decrement at 0 is ignored and never underflows.
- Same-cycle writeback and decode reading that register: the hazard uses the registered count, so decode stalls one extra cycle. No bypass.
- FSM:
  - RUN → MEM_WAIT when issue & dec_mem. dcache_req pulses for 1 cycle on entry.
  - MEM_WAIT: stall_fetch = stall_dec = 1, bubble_alu = 0 (ALU holds), issue = 0.
  - MEM_WAIT → RUN on dcache_done.
  - MEM_WAIT timeout: after MEM_TIMEOUT cycles without done, pulse mem_err, return to RUN.
  - RUN → FLUSH on alu_jmp: same cycle pc_redirect = 1, flush_dec = 1, issue = 0.
  - FLUSH (1 cycle): flush_dec = 1 and fetch_valid is ignored, discarding the in-flight fetch. Then → RUN.
- alu_jmp during MEM_WAIT is ignored: the ALU is held, so alu_jmp cannot originate while in MEM_WAIT.
- dcache_done in RUN is ignored.
- Reset mid-MEM_WAIT: immediate return to RUN, counters cleared, no dcache_req.
- Latency: hazard-free instruction issues the cycle after fetch_valid; a scoreboard bit clears the cycle after wb_valid.

Test Plan:
- Back-to-back independent: fetch rd=x5, then rs1=x6 → issue every cycle; busy_mask bit5 set one cycle after issue, cleared one cycle after wb_valid/wb_rd=5.
- RAW stall: issue rd=x3, next reads x3 → stall_dec=1, bubble_alu=1 until the cycle after wb_valid rd=3, then issue=1.
- x0 handling: rd=x0 writer, then rs1=x0 reader → no busy bit, no stall.
- Load: issue dec_mem=1 → dcache_req pulse, stalls held 7 cycles, dcache_done on cycle 7 → RUN next cycle, issue resumes.
- Jump: alu_jmp while fetch_valid=1 → pc_redirect=1 and flush_dec=1 that cycle, next fetched instruction dropped, dec_valid=0.
- Saturation/reset: three outstanding writes to x7 → fourth writer stalls. Assert rst low mid-MEM_WAIT → busy_mask=0, all outputs 0 asynchronously.
